// File: rtl/two_bit_demux.sv
// two_bit_demux: 1-to-4 valid/ready demultiplexer with a one-entry holding register per channel.
// Per-channel accepted-word counters are built only when DEMUX_COUNT_EN is defined.
module two_bit_demux #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_dest,
    input  logic [WIDTH-1:0]         in_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [4*WIDTH-1:0]       out_data,
    input  logic                     count_clr,
    output logic [4*COUNT_WIDTH-1:0] count_out
);

    // state | meaning
    // EMPTY | holding register free, out_valid[k]=0
    // FULL  | holding register holds an undelivered word, out_valid[k]=1
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e      state_q [4];
    chan_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];

    logic       accept;
    logic [3:0] dest_sel;
    logic [3:0] accept_k;

    // A full channel can still take a word if its consumer drains it at the same edge.
    always_comb begin
        in_ready = (state_q[in_dest] == EMPTY) | out_ready[in_dest];
        accept   = in_valid & in_ready;
        dest_sel = 4'b0001 << in_dest;
        accept_k = accept ? dest_sel : 4'b0000;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept_k[k]) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if ((state_q[k] == FULL) && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    // Lanes expose the holding registers directly; data stays stale after a drain.
    always_comb begin
        out_valid = 4'b0000;
        out_data  = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]                 = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH]   = data_q[k];
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q [4];
    logic [COUNT_WIDTH-1:0] count_d [4];

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            count_d[k] = count_q[k];
            if (count_clr) begin
                count_d[k] = '0;
            end else if (accept_k[k]) begin
                count_d[k] = count_q[k] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= count_d[k];
            end
        end
    end

    always_comb begin
        count_out = '0;
        for (int k = 0; k < 4; k++) begin
            count_out[k*COUNT_WIDTH +: COUNT_WIDTH] = count_q[k];
        end
    end
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign count_out        = '0;
`endif

endmodule

// File: tb/tb_two_bit_demux.sv
// Scoreboard bench for two_bit_demux: per-channel expected-word queues filled on accept,
// popped on drain; counter model follows DEMUX_COUNT_EN.
module tb_two_bit_demux;
    localparam int W  = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_dest;
    logic [W-1:0]    in_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*W-1:0]  out_data;
    logic            count_clr;
    logic [4*CW-1:0] count_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  sb_q [4][$];
    logic [CW-1:0] cnt_exp [4];

    two_bit_demux #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count_clr (count_clr),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick(output logic acc_o);
        logic          acc;
        logic [W-1:0]  exp_w;
        logic          model_rdy;
        #4;
        model_rdy = (sb_q[in_dest].size() == 0) || out_ready[in_dest];
        chk("in_ready", in_ready, model_rdy);
        acc = in_valid && model_rdy;
        for (int k = 0; k < 4; k++) begin
            if (sb_q[k].size() != 0 && out_ready[k]) begin
                exp_w = sb_q[k].pop_front();
                chk("drain_data", out_data[k*W +: W], exp_w);
            end
        end
        if (acc) sb_q[in_dest].push_back(in_data);
`ifdef DEMUX_COUNT_EN
        for (int k = 0; k < 4; k++) begin
            if (count_clr) cnt_exp[k] = '0;
            else if (acc && in_dest == 2'(k)) cnt_exp[k] = cnt_exp[k] + 1'b1;
        end
`endif
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", out_valid[k], sb_q[k].size() != 0);
            if (sb_q[k].size() != 0) chk("lane_data", out_data[k*W +: W], sb_q[k][0]);
            chk("count_out", count_out[k*CW +: CW], cnt_exp[k]);
        end
        acc_o = acc;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] d, input logic [W-1:0] w);
        logic a;
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = w;
        tick(a);
    endtask

    task automatic idle();
        logic a;
        in_valid = 1'b0;
        tick(a);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sb_q[k].delete();
            cnt_exp[k] = '0;
        end
    endtask

    initial begin
        logic          a;
        logic [W-1:0]  w;
        logic [CW-1:0] exp_wrap;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dest   = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        count_clr = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_data", out_data, '0);
        chk("rst_count", count_out, '0);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_dest = 2'(d);
            #1;
            chk("rst_ready", in_ready, 1'b1);
        end
        @(negedge clk);

        // Basic routing, one-hot valid per cycle
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            w = 32'h1111_1111 * (k + 1);
            send(2'(k), w);
            chk("rt_onehot", out_valid, 4'b0001 << k);
            chk("rt_lane", out_data[k*W +: W], w);
        end
        idle();
        chk("rt_drained", out_valid, 4'b0000);

        // Back-pressure on channel 2
        out_ready = 4'b1011;
        send(2'd2, 32'hA);
        in_dest = 2'd2;
        in_data = 32'hB;
        #1;
        chk("bp_ready0", in_ready, 1'b0);
        tick(a);
        chk("bp_hold", out_data[2*W +: W], 32'hA);
        chk("bp_ready1", in_ready, 1'b0);
        tick(a);
        chk("bp_still", out_data[2*W +: W], 32'hA);
        out_ready = 4'b1111;
        tick(a);
        chk("bp_swap_v", out_valid[2], 1'b1);
        chk("bp_swap_d", out_data[2*W +: W], 32'hB);
        send(2'd0, 32'hC);
        chk("bp_c", out_data[0*W +: W], 32'hC);
        idle();

        // Drain + fill in the same cycle
        out_ready = 4'b1101;
        send(2'd1, 32'h5);
        out_ready = 4'b1111;
        send(2'd1, 32'h6);
        chk("df_valid", out_valid[1], 1'b1);
        chk("df_data", out_data[1*W +: W], 32'h6);
        idle();

        // Reset mid-operation
        out_ready = 4'b0000;
        send(2'd0, 32'hDEAD_0000);
        send(2'd3, 32'hDEAD_0003);
        in_valid = 1'b0;
        chk("mr_full", out_valid, 4'b1001);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_async_v", out_valid, 4'b0000);
        chk("mr_async_d", out_data, '0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_dest = 2'(d);
            #1;
            chk("mr_ready", in_ready, 1'b1);
        end
        @(negedge clk);

        // Counter wrap and clear priority
        out_ready = 4'b1111;
        for (int i = 0; i < 17; i++) send(2'd3, W'(i));
`ifdef DEMUX_COUNT_EN
        exp_wrap = 4'd1;
`else
        exp_wrap = 4'd0;
`endif
        chk("cnt_wrap", count_out[3*CW +: CW], exp_wrap);
        count_clr = 1'b1;
        send(2'd3, 32'h77);
        count_clr = 1'b0;
        chk("cnt_clr", count_out[3*CW +: CW], 4'd0);
        idle();

        // Random traffic; producer holds a word until it is accepted
        a = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || a) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_dest  = 2'($urandom_range(0, 3));
                in_data  = $urandom;
            end
            out_ready = 4'($urandom);
            count_clr = ($urandom_range(0, 31) == 0);
            tick(a);
        end
        count_clr = 1'b0;
        out_ready = 4'b1111;
        idle();
        idle();
        chk("end_empty", out_valid, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
